// File: rtl/lsp_to_lsf_fsm.sv
// LSP-to-LSF converter: reads M LSP coefficients from scratch memory and writes Q13 LSFs
// back, bit-exact to G.729 Lsp_lsf2 (arccos table search plus slope-corrected interpolation).
module lsp_to_lsf_fsm #(
  parameter logic [10:0] LSP_BASE = 11'h100,
  parameter logic [10:0] LSF_BASE = 11'h140,
  parameter int unsigned M        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] memIn,
  output logic [10:0] memReadAddr,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);
  localparam int unsigned IW   = 4;
  localparam int unsigned INDW = 6;
  localparam logic [IW-1:0]   LAST       = IW'(M - 1);
  localparam logic [INDW-1:0] IND_TOP    = INDW'(63);
  localparam logic signed [15:0] TWO_PI_Q12 = 16'sd25736;

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEARCH, CALCFREQ, CALCLSF, WRITE, DONE} stateT;

  // cos(w) table, descending from 1.0 to about -1.0 in Q15
  function automatic logic signed [15:0] table2(input logic [INDW-1:0] k);
    logic signed [15:0] t;
    t = '0;
    case (k)
      6'd0:  t =  16'sd32767; 6'd1:  t =  16'sd32729; 6'd2:  t =  16'sd32610; 6'd3:  t =  16'sd32413;
      6'd4:  t =  16'sd32138; 6'd5:  t =  16'sd31786; 6'd6:  t =  16'sd31357; 6'd7:  t =  16'sd30853;
      6'd8:  t =  16'sd30274; 6'd9:  t =  16'sd29622; 6'd10: t =  16'sd28899; 6'd11: t =  16'sd28106;
      6'd12: t =  16'sd27246; 6'd13: t =  16'sd26320; 6'd14: t =  16'sd25330; 6'd15: t =  16'sd24279;
      6'd16: t =  16'sd23170; 6'd17: t =  16'sd22006; 6'd18: t =  16'sd20788; 6'd19: t =  16'sd19520;
      6'd20: t =  16'sd18205; 6'd21: t =  16'sd16846; 6'd22: t =  16'sd15447; 6'd23: t =  16'sd14010;
      6'd24: t =  16'sd12540; 6'd25: t =  16'sd11039; 6'd26: t =  16'sd9512;  6'd27: t =  16'sd7962;
      6'd28: t =  16'sd6393;  6'd29: t =  16'sd4808;  6'd30: t =  16'sd3212;  6'd31: t =  16'sd1608;
      6'd32: t =  16'sd0;     6'd33: t = -16'sd1608;  6'd34: t = -16'sd3212;  6'd35: t = -16'sd4808;
      6'd36: t = -16'sd6393;  6'd37: t = -16'sd7962;  6'd38: t = -16'sd9512;  6'd39: t = -16'sd11039;
      6'd40: t = -16'sd12540; 6'd41: t = -16'sd14010; 6'd42: t = -16'sd15447; 6'd43: t = -16'sd16846;
      6'd44: t = -16'sd18205; 6'd45: t = -16'sd19520; 6'd46: t = -16'sd20788; 6'd47: t = -16'sd22006;
      6'd48: t = -16'sd23170; 6'd49: t = -16'sd24279; 6'd50: t = -16'sd25330; 6'd51: t = -16'sd26320;
      6'd52: t = -16'sd27246; 6'd53: t = -16'sd28106; 6'd54: t = -16'sd28899; 6'd55: t = -16'sd29622;
      6'd56: t = -16'sd30274; 6'd57: t = -16'sd30853; 6'd58: t = -16'sd31357; 6'd59: t = -16'sd31786;
      6'd60: t = -16'sd32138; 6'd61: t = -16'sd32413; 6'd62: t = -16'sd32610; 6'd63: t = -16'sd32729;
      default: t = '0;
    endcase
    return t;
  endfunction

  // Interpolation slope between adjacent table2 points
  function automatic logic signed [15:0] slopeAcos(input logic [INDW-1:0] k);
    logic signed [15:0] s;
    s = '0;
    case (k)
      6'd0:  s = -16'sd26887; 6'd1:  s = -16'sd8812;  6'd2:  s = -16'sd5323;  6'd3:  s = -16'sd3813;
      6'd4:  s = -16'sd2979;  6'd5:  s = -16'sd2444;  6'd6:  s = -16'sd2081;  6'd7:  s = -16'sd1811;
      6'd8:  s = -16'sd1608;  6'd9:  s = -16'sd1450;  6'd10: s = -16'sd1322;  6'd11: s = -16'sd1219;
      6'd12: s = -16'sd1132;  6'd13: s = -16'sd1059;  6'd14: s = -16'sd998;   6'd15: s = -16'sd946;
      6'd16: s = -16'sd901;   6'd17: s = -16'sd861;   6'd18: s = -16'sd827;   6'd19: s = -16'sd797;
      6'd20: s = -16'sd772;   6'd21: s = -16'sd750;   6'd22: s = -16'sd730;   6'd23: s = -16'sd713;
      6'd24: s = -16'sd699;   6'd25: s = -16'sd687;   6'd26: s = -16'sd677;   6'd27: s = -16'sd668;
      6'd28: s = -16'sd662;   6'd29: s = -16'sd657;   6'd30: s = -16'sd654;   6'd31: s = -16'sd652;
      6'd32: s = -16'sd652;   6'd33: s = -16'sd654;   6'd34: s = -16'sd657;   6'd35: s = -16'sd662;
      6'd36: s = -16'sd668;   6'd37: s = -16'sd677;   6'd38: s = -16'sd687;   6'd39: s = -16'sd699;
      6'd40: s = -16'sd713;   6'd41: s = -16'sd730;   6'd42: s = -16'sd750;   6'd43: s = -16'sd772;
      6'd44: s = -16'sd797;   6'd45: s = -16'sd827;   6'd46: s = -16'sd861;   6'd47: s = -16'sd901;
      6'd48: s = -16'sd946;   6'd49: s = -16'sd998;   6'd50: s = -16'sd1059;  6'd51: s = -16'sd1132;
      6'd52: s = -16'sd1219;  6'd53: s = -16'sd1322;  6'd54: s = -16'sd1450;  6'd55: s = -16'sd1608;
      6'd56: s = -16'sd1811;  6'd57: s = -16'sd2081;  6'd58: s = -16'sd2444;  6'd59: s = -16'sd2979;
      6'd60: s = -16'sd3813;  6'd61: s = -16'sd5323;  6'd62: s = -16'sd8812;  6'd63: s = -16'sd26887;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic signed [15:0] sat17(input logic signed [16:0] x);
    if (x[16] != x[15]) return x[16] ? 16'sh8000 : 16'sh7FFF;
    return x[15:0];
  endfunction

  function automatic logic signed [15:0] sat32(input logic signed [31:0] x);
    if (x > 32'sd32767) return 16'sh7FFF;
    if (x < -32'sd32768) return 16'sh8000;
    return x[15:0];
  endfunction

  stateT state, stateNext;
  logic [IW-1:0]      i, iNext;
  logic [INDW-1:0]    ind, indNext;
  logic signed [15:0] lsp, lspNext;
  logic signed [15:0] freq, freqNext;
  logic [10:0]        readAddrNext, writeAddrNext;
  logic [31:0]        outNext;
  logic               writeEnNext, doneNext;

  logic signed [15:0] tabVal, slopeVal, offset, indShift, freqC, lsfC;
  logic signed [16:0] offsetDiff, freqSum;
  logic signed [31:0] slopeProd, lTmp, lTmpShr, lsfProd, lsfShr;
  logic               unusedMemHi;

  assign unusedMemHi = ^memIn[31:16];

  // Lsp_lsf2 datapath: offset, L_mult with saturation, freq add, scale by 2*pi
  always_comb begin
    tabVal     = table2(ind);
    slopeVal   = slopeAcos(ind);
    offsetDiff = 17'(lsp) - 17'(tabVal);
    offset     = sat17(offsetDiff);
    slopeProd  = 32'(slopeVal) * 32'(offset);
    lTmp       = (slopeVal == 16'sh8000 && offset == 16'sh8000) ? 32'sh7FFF_FFFF
                                                                 : {slopeProd[30:0], 1'b0};
    lTmpShr    = lTmp >>> 12;
    indShift   = 16'({ind, 9'd0});
    freqSum    = 17'(indShift) + 17'($signed(lTmpShr[15:0]));
    freqC      = sat17(freqSum);
    lsfProd    = 32'(freq) * 32'(TWO_PI_Q12);
    lsfShr     = lsfProd >>> 15;
    lsfC       = sat32(lsfShr);
  end

  always_comb begin
    stateNext     = state;
    iNext         = i;
    indNext       = ind;
    lspNext       = lsp;
    freqNext      = freq;
    readAddrNext  = memReadAddr;
    writeAddrNext = memWriteAddr;
    outNext       = memOut;
    writeEnNext   = 1'b0;
    doneNext      = done;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          iNext        = LAST;
          indNext      = IND_TOP;
          doneNext     = 1'b0;
          readAddrNext = {LSP_BASE[10:4], LAST};
          stateNext    = READ;
        end
      end
      READ: stateNext = WAIT;
      WAIT: begin
        lspNext   = memIn[15:0];
        stateNext = SEARCH;
      end
      // ind persists across coefficients and stops at 0
      SEARCH: begin
        if (ind != '0 && tabVal < lsp) begin
          indNext = ind - INDW'(1);
          if (ind == INDW'(1)) stateNext = CALCFREQ;
        end else begin
          stateNext = CALCFREQ;
        end
      end
      CALCFREQ: begin
        freqNext  = freqC;
        stateNext = CALCLSF;
      end
      CALCLSF: begin
        outNext       = {{16{lsfC[15]}}, lsfC};
        writeAddrNext = {LSF_BASE[10:4], i};
        writeEnNext   = 1'b1;
        stateNext     = WRITE;
      end
      WRITE: begin
        if (i == '0) begin
          doneNext  = 1'b1;
          stateNext = DONE;
        end else begin
          iNext        = i - IW'(1);
          readAddrNext = {LSP_BASE[10:4], i - IW'(1)};
          stateNext    = READ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      i            <= LAST;
      ind          <= IND_TOP;
      lsp          <= '0;
      freq         <= '0;
      memReadAddr  <= '0;
      memWriteAddr <= '0;
      memOut       <= '0;
      memWriteEn   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= stateNext;
      i            <= iNext;
      ind          <= indNext;
      lsp          <= lspNext;
      freq         <= freqNext;
      memReadAddr  <= readAddrNext;
      memWriteAddr <= writeAddrNext;
      memOut       <= outNext;
      memWriteEn   <= writeEnNext;
      done         <= doneNext;
    end
  end
endmodule

// File: tb/tb_lsp_to_lsf_fsm.sv
// Bench for lsp_to_lsf_fsm: hand-computed vector table, corner sequences and a
// C-model scoreboard over random LSP frames.
module tb_lsp_to_lsf_fsm;
  localparam logic [10:0] LSP_BASE = 11'h100;
  localparam logic [10:0] LSF_BASE = 11'h140;
  localparam int M = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] memIn = '0;
  logic [10:0] memReadAddr, memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn, done;

  lsp_to_lsf_fsm #(.LSP_BASE(LSP_BASE), .LSF_BASE(LSF_BASE), .M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .memIn(memIn),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
    .memWriteEn(memWriteEn), .done(done)
  );

  always #5 clk = ~clk;

  int t2 [64] = '{
     32767, 32729, 32610, 32413, 32138, 31786, 31357, 30853,
     30274, 29622, 28899, 28106, 27246, 26320, 25330, 24279,
     23170, 22006, 20788, 19520, 18205, 16846, 15447, 14010,
     12540, 11039,  9512,  7962,  6393,  4808,  3212,  1608,
         0, -1608, -3212, -4808, -6393, -7962, -9512,-11039,
    -12540,-14010,-15447,-16846,-18205,-19520,-20788,-22006,
    -23170,-24279,-25330,-26320,-27246,-28106,-28899,-29622,
    -30274,-30853,-31357,-31786,-32138,-32413,-32610,-32729};
  int sl [64] = '{
    -26887, -8812, -5323, -3813, -2979, -2444, -2081, -1811,
     -1608, -1450, -1322, -1219, -1132, -1059,  -998,  -946,
      -901,  -861,  -827,  -797,  -772,  -750,  -730,  -713,
      -699,  -687,  -677,  -668,  -662,  -657,  -654,  -652,
      -652,  -654,  -657,  -662,  -668,  -677,  -687,  -699,
      -713,  -730,  -750,  -772,  -797,  -827,  -861,  -901,
      -946,  -998, -1059, -1132, -1219, -1322, -1450, -1608,
     -1811, -2081, -2444, -2979, -3813, -5323, -8812,-26887};

  typedef struct { logic [10:0] addr; logic [31:0] data; } expT;
  typedef struct { int idx; int lsf; } vecT;

  expT         sbq[$];
  expT         monE;
  logic [15:0] lspMem [16];
  logic [31:0] capLsf [16];
  int          checks = 0;
  int          errors = 0;
  int          writeCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Synchronous-read scratch memory; upper half is junk the DUT must ignore
  always @(posedge clk) begin
    if (memReadAddr[10:4] == LSP_BASE[10:4] && memReadAddr[3:0] < 4'd10)
      memIn <= {16'hA5A5, lspMem[memReadAddr[3:0]]};
    else
      memIn <= 32'h5A5A_5A5A;
  end

  // Scoreboard: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (memWriteEn) begin
      writeCount++;
      capLsf[memWriteAddr[3:0]] = memOut;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedWrite: got addr 0x%03h data 0x%08h, expected no write",
                 memWriteAddr, memOut);
      end else begin
        monE = sbq.pop_front();
        check("writeAddr", 32'(memWriteAddr), 32'(monE.addr));
        check("writeData", memOut, monE.data);
      end
    end
  end

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // C reference: one Lsp_lsf2 loop iteration
  task automatic modelCoef(input int lsp, inout int ind, output int lsf);
    int offset, lo, freq;
    longint ltmp, sh;
    logic signed [15:0] lo16;
    while (t2[ind] < lsp) begin
      ind--;
      if (ind <= 0) break;
    end
    offset = sat16(lsp - t2[ind]);
    ltmp = 2 * longint'(sl[ind]) * longint'(offset);
    if (ltmp > 64'sd2147483647) ltmp = 64'sd2147483647;
    sh   = ltmp >>> 12;
    lo16 = 16'(sh);
    lo   = int'(lo16);
    freq = sat16(ind * 512 + lo);
    lsf  = sat16((freq * 25736) >>> 15);
  endtask

  task automatic loadFrame(input int lspv [10]);
    int ind, lsf;
    ind = 63;
    for (int k = 0; k < M; k++) lspMem[k] = 16'(lspv[k]);
    for (int k = M - 1; k >= 0; k--) begin
      modelCoef(lspv[k], ind, lsf);
      sbq.push_back('{{LSF_BASE[10:4], 4'(k)}, 32'(lsf)});
    end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    int n;
    n = 0;
    while (!done && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic runFrame(input string name, input int lspv [10]);
    int wc0;
    loadFrame(lspv);
    wc0 = writeCount;
    pulseStart();
    check({name, "_doneCleared"}, 32'(done), 32'd0);
    waitDone({name, "_done"}, 400);
    check({name, "_writes"}, 32'(writeCount - wc0), 32'd10);
    check({name, "_sbEmpty"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic randFrame(input int f, output int lspv [10]);
    int q[$];
    for (int k = 0; k < M; k++) q.push_back(int'($urandom_range(0, 65535)) - 32768);
    if (f % 10 == 0) begin
      q[0] = 32767;
      q[9] = -32768;
    end
    if (f % 4 != 3) q.rsort();
    for (int k = 0; k < M; k++) lspv[k] = q[k];
  endtask

  vecT vecs [10];
  int  lspv [10];
  int  wc0;

  initial begin
    // Exact table hits: offset 0, so lsf = floor(idx*512*25736 / 32768) = floor(idx*402.125)
    vecs[9] = '{63, 25333}; vecs[8] = '{56, 22519}; vecs[7] = '{48, 19302};
    vecs[6] = '{40, 16085}; vecs[5] = '{32, 12868}; vecs[4] = '{24, 9651};
    vecs[3] = '{16, 6434};  vecs[2] = '{8, 3217};   vecs[1] = '{1, 402};
    vecs[0] = '{0, 0};

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_memWriteEn", 32'(memWriteEn), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_readAddr", 32'(memReadAddr), 32'd0);
    check("rst_writeAddr", 32'(memWriteAddr), 32'd0);
    check("rst_memOut", memOut, 32'd0);
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("idle_noWrites", 32'(writeCount), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    for (int k = 0; k < M; k++) lspv[k] = t2[vecs[k].idx];
    runFrame("tableHit", lspv);
    for (int k = 0; k < M; k++)
      check($sformatf("tableHit_lsf%0d", k), capLsf[k], 32'(vecs[k].lsf));

    for (int k = 0; k < M; k++) lspv[k] = 32767;
    runFrame("floor", lspv);
    for (int k = 0; k < M; k++)
      check($sformatf("floor_lsf%0d", k), capLsf[k], 32'd0);

    // Start while busy is ignored; done holds until the next accepted start
    randFrame(1, lspv);
    loadFrame(lspv);
    wc0 = writeCount;
    pulseStart();
    repeat (30) @(posedge clk);
    pulseStart();
    waitDone("busy_done", 400);
    repeat (20) @(posedge clk);
    #1;
    check("busy_writes", 32'(writeCount - wc0), 32'd10);
    check("busy_doneHeld", 32'(done), 32'd1);
    check("busy_sbEmpty", 32'(sbq.size()), 32'd0);

    // Reset while coefficient 5 is searching
    randFrame(2, lspv);
    lspv[5] = -32768;
    loadFrame(lspv);
    wc0 = writeCount;
    pulseStart();
    for (int n = 0; n < 400 && writeCount < wc0 + 4; n++) @(posedge clk);
    check("midrst_reached", 32'(writeCount - wc0), 32'd4);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_memWriteEn", 32'(memWriteEn), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_readAddr", 32'(memReadAddr), 32'd0);
    check("midrst_writeAddr", 32'(memWriteAddr), 32'd0);
    check("midrst_memOut", memOut, 32'd0);
    sbq.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    runFrame("afterRst", lspv);

    for (int f = 0; f < 120; f++) begin
      randFrame(f, lspv);
      runFrame($sformatf("regr%0d", f), lspv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
